seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexing scanner for the Basys 3 four-digit 7-segment display. Sits directly upstream of the hex segment decoder. It holds a 16-bit display value and rotates the active anode at a fixed refresh rate. On each dwell slot it presents the selected 4-bit nibble to the decoder. Value updates are double-buffered and committed only at frame boundaries, so a digit never shows a torn value mid-frame.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles per digit dwell. At 100 MHz that is 1 ms per digit and 250 Hz per frame. Minimum 2.

Ports:
- `clk` in 1: 100 MHz system clock; all state on rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `value` in 16: display value. Nibble 0 is `value[3:0]`, shown on the rightmost digit (`an[0]`).
- `load` in 1: single-cycle strobe; captures `value` into the pending buffer.
- `blank_lz` in 1: level; when 1, leading-zero digits are blanked.
- `enable` in 1: level; when 0, all anodes are off and scanning continues.
- `an` out 4: active-low anode drive.
- `digit` out 4: nibble for the downstream segment decoder.
- `digit_sel` out 2: current scan index, 0..3.
- `frame_tick` out 1: one-cycle pulse at each frame wrap.
- `pending` out 1: a loaded value is awaiting commit.

## Operation
- Registers:
  - prescaler `pcnt`, width clog2(REFRESH_DIV)
  - scan index `idx` (2 bits)
  - active value `act` (16)
  - pending value `pend` (16)
  - `pending` flag
  - `frame_tick` (registered)
- Reset (`rst`=0, asynchronous):
  - `pcnt`=0, `idx`=0, `act`=16'h0000, `pend`=16'h0000, `pending`=0, `frame_tick`=0.
  - `an` is forced to 4'b1111 while `rst` is low.
  - `digit`=4'h0, `digit_sel`=0.
- Prescaler:
  - `pcnt` counts 0..REFRESH_DIV-1.
  - At terminal count it wraps to 0, and `idx` advances mod 4 (3 wraps to 0).
- Frame commit occurs on the edge where terminal count coincides with `idx`==3:
  - `frame_tick`<=1 for exactly one cycle.
  - If `pending`==1 before the edge: `act`<=`pend`, `pending`<=0.
- Load:
  - On an edge with `load`=1: `pend`<=`value`, `pending`<=1.
  - Repeated loads before commit overwrite `pend`; the last one wins.
- Load in the commit cycle:
  - The old `pend` commits to `act`.
  - The new `value` goes into `pend`, and `pending` stays 1.
  - The new value commits at the next frame.
- Outputs (combinational from registers):
  - `digit` = `act[4*idx+3 : 4*idx]`.
  - `digit_sel` = `idx`.
- Blanking: digit i (i=1..3) is blanked when `blank_lz`=1 and `act` nibbles i..3 are all zero. Digit 0 is never blanked.
- Anode drive:
  - `an` = ~(4'b0001 << `idx`) when `enable`=1 and the current digit is not blanked.
  - Otherwise `an` = 4'b1111.
- `enable` does not stop `pcnt`/`idx`, and it does not block load or commit.

## Timing
- Digit dwell is exactly REFRESH_DIV cycles. A frame is 4×REFRESH_DIV cycles.
- After reset release, digit 0 is displayed first, for REFRESH_DIV cycles.
- Commit latency from `load`: at most one full frame plus one cycle. The new value is visible on `digit` starting with the first dwell of `idx`=0 after commit.
- `frame_tick` is high in the first cycle of `idx`=0 of the new frame. The first frame after reset also produces a tick.
- `enable`/`blank_lz` changes affect `an` in the same cycle (combinational).
- Reset asserted mid-frame:
  - Immediate return to reset values.
  - Any pending value is discarded.

## Test plan
All scenarios use REFRESH_DIV=4.
1. Reset, then `load` value=16'h1234 once, then run 3 frames.
   - Required: after the first commit, `digit` sequence per dwell is 4,3,2,1.
   - Required: `an` sequence is 1110,1101,1011,0111.
   - Required: each dwell lasts 4 cycles; `frame_tick` pulses every 16 cycles.
2. Load 16'hABCD in mid-frame (`idx`=1).
   - Required: `pending`=1 and `digit` still shows old `act` until the frame wrap.
   - Required: at `idx`=0 of the next frame, `digit`=4'hD and `pending`=0.
3. Load 16'h0000, then 16'h00F0, both within one frame.
   - Required: only 16'h00F0 commits.
4. `blank_lz`=1 with `act`=16'h0050.
   - Required: `an`=1111 during `idx`=3 and `idx`=2; active during `idx`=1 and `idx`=0.
   - With `act`=16'h0000: only `idx`=0 shows, with `an`=1110.
5. `load` asserted on the exact commit edge while `pending`=1 with `pend`=16'h1111, new value 16'h2222.
   - Required: `act`=16'h1111, `pend`=16'h2222, `pending`=1.
   - Required: 16'h2222 commits one frame later.
6. Assert `rst` low at `idx`=2 with `pending`=1, and separately drive `enable`=0.
   - Required on reset: `an`=1111 immediately; after release `idx`=0, `act`=0, `pending`=0.
   - Required with `enable`=0: `an`=1111 while `idx` keeps advancing.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Four-digit 7-segment scanner: rotates the active anode every REFRESH_DIV cycles
// and commits double-buffered display values only at frame boundaries.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [3:0]  digit,
  output logic [1:0]  digit_sel,
  output logic        frame_tick,
  output logic        pending
);

  localparam int unsigned PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       act_q, act_d;
  logic [15:0]       pend_q, pend_d;
  logic              pending_q, pending_d;
  logic              frame_tick_q, frame_tick_d;
  logic              term_cnt, commit;
  logic [3:0]        blank_vec;

  // Next-state: prescaler, scan index, frame commit and load capture
  always_comb begin
    pcnt_d       = pcnt_q + PCNT_W'(1);
    idx_d        = idx_q;
    act_d        = act_q;
    pend_d       = pend_q;
    pending_d    = pending_q;
    frame_tick_d = 1'b0;
    term_cnt     = (pcnt_q == PCNT_MAX);
    commit       = term_cnt && (idx_q == 2'd3);
    if (term_cnt) begin
      pcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    if (commit) begin
      frame_tick_d = 1'b1;
      pending_d    = 1'b0;
      if (pending_q) act_d = pend_q;
    end
    // A load on the commit edge refills pend after the old value moves to act
    if (load) begin
      pend_d    = value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      act_q        <= '0;
      pend_q       <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Leading-zero blanking: digit i dark when nibbles i..3 are all zero
  always_comb begin
    blank_vec[0] = 1'b0;
    blank_vec[1] = (act_q[15:4]  == 12'h000);
    blank_vec[2] = (act_q[15:8]  == 8'h00);
    blank_vec[3] = (act_q[15:12] == 4'h0);
  end

  always_comb begin
    digit     = act_q[{idx_q, 2'b00} +: 4];
    digit_sel = idx_q;
    if (!rst || !enable || (blank_lz && blank_vec[idx_q])) an = 4'b1111;
    else                                                   an = ~(4'b0001 << idx_q);
  end

  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule
